// File: rtl/uart_rx.sv
// 8N1 UART receiver with two-flop input synchronizer and mid-bit sampling.
// Define UART_RX_FRAMING_CHECK_EN to flag low stop bits on o_Rx_Frame_Err instead of delivering the byte.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Busy,
  output logic       o_Rx_Frame_Err
);

  localparam logic [9:0] LAST_CNT = 10'(CLKS_PER_BIT - 1);
  localparam logic [9:0] HALF_CNT = 10'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t      state, state_next;
  logic        rx_meta, rx_sync;
  logic [9:0]  clk_count, count_next;
  logic [2:0]  bit_index, index_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  rx_byte, byte_next;
  logic        rx_dv, dv_next;
  logic        rx_busy, busy_next;
`ifdef UART_RX_FRAMING_CHECK_EN
  logic        frame_err, err_next;
`endif

  // Synchronizer idles high so reset never looks like a start bit
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift_reg <= '0;
      rx_byte   <= '0;
      rx_dv     <= 1'b0;
      rx_busy   <= 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      clk_count <= count_next;
      bit_index <= index_next;
      shift_reg <= shift_next;
      rx_byte   <= byte_next;
      rx_dv     <= dv_next;
      rx_busy   <= busy_next;
`ifdef UART_RX_FRAMING_CHECK_EN
      frame_err <= err_next;
`endif
    end
  end

  // Every state transition below also clears the bit-period counter
  always_comb begin
    state_next = state;
    count_next = clk_count;
    index_next = bit_index;
    shift_next = shift_reg;
    byte_next  = rx_byte;
    dv_next    = 1'b0;
    busy_next  = rx_busy;
`ifdef UART_RX_FRAMING_CHECK_EN
    err_next   = 1'b0;
`endif
    case (state)
      IDLE: begin
        count_next = '0;
        index_next = '0;
        if (!rx_sync) begin
          state_next = START;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (clk_count == HALF_CNT) begin
          count_next = '0;
          if (!rx_sync) begin
            state_next = DATA;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end else begin
          count_next = clk_count + 10'd1;
        end
      end
      DATA: begin
        if (clk_count == LAST_CNT) begin
          count_next            = '0;
          shift_next[bit_index] = rx_sync;
          if (bit_index == 3'd7) begin
            state_next = STOP;
            index_next = '0;
          end else begin
            index_next = bit_index + 3'd1;
          end
        end else begin
          count_next = clk_count + 10'd1;
        end
      end
      STOP: begin
        if (clk_count == LAST_CNT) begin
          count_next = '0;
          state_next = CLEANUP;
`ifdef UART_RX_FRAMING_CHECK_EN
          if (rx_sync) begin
            byte_next = shift_reg;
            dv_next   = 1'b1;
          end else begin
            err_next = 1'b1;
          end
`else
          byte_next = shift_reg;
          dv_next   = 1'b1;
`endif
        end else begin
          count_next = clk_count + 10'd1;
        end
      end
      CLEANUP: begin
        // Wait for the line to go idle so a held-low break cannot retrigger
        count_next = '0;
        if (rx_sync) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        index_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign o_Rx_DV   = rx_dv;
  assign o_Rx_Byte = rx_byte;
  assign o_Rx_Busy = rx_busy;
`ifdef UART_RX_FRAMING_CHECK_EN
  assign o_Rx_Frame_Err = frame_err;
`else
  assign o_Rx_Frame_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: frames push expected events,
// a negedge monitor pops and compares each o_Rx_DV / o_Rx_Frame_Err pulse.
module tb_uart_rx;

  localparam int CLKS = 16;
`ifdef UART_RX_FRAMING_CHECK_EN
  localparam bit FRAMING = 1'b1;
`else
  localparam bit FRAMING = 1'b0;
`endif

  logic       i_Clock = 1'b0;
  logic       i_Reset;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Busy;
  logic       o_Rx_Frame_Err;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         start_cycle;
  } exp_t;

  exp_t       exp_q[$];
  int         cycle = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_byte = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_Rx_Serial    (i_Rx_Serial),
    .o_Rx_DV        (o_Rx_DV),
    .o_Rx_Byte      (o_Rx_Byte),
    .o_Rx_Busy      (o_Rx_Busy),
    .o_Rx_Frame_Err (o_Rx_Frame_Err)
  );

  always #5 i_Clock = ~i_Clock;

  always @(posedge i_Clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_dv"},   32'(o_Rx_DV),        32'd0);
    checkOutput({tag, "_byte"}, 32'(o_Rx_Byte),      32'd0);
    checkOutput({tag, "_busy"}, 32'(o_Rx_Busy),      32'd0);
    checkOutput({tag, "_ferr"}, 32'(o_Rx_Frame_Err), 32'd0);
  endtask

  // Drives one frame starting at the current negedge; abort_bit >= 0 resets mid-frame
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int abort_bit);
    exp_t e;
    e.start_cycle = cycle;
    if (abort_bit < 0) begin
      if (stop_bit || !FRAMING) begin
        e.is_err  = 1'b0;
        e.data    = data;
        last_byte = data;
      end else begin
        e.is_err = 1'b1;
        e.data   = last_byte;
      end
      exp_q.push_back(e);
    end
    i_Rx_Serial = 1'b0;
    repeat (CLKS) @(negedge i_Clock);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        #1;
        checkResetOutputs("midframe_reset");
        last_byte = 8'h00;
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;
        repeat (2 * CLKS) @(negedge i_Clock);
        return;
      end
      i_Rx_Serial = data[i];
      repeat (CLKS) @(negedge i_Clock);
    end
    i_Rx_Serial = stop_bit;
    repeat (CLKS) @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
  endtask

  // Monitor: every output pulse must match the oldest pending expectation
  always @(negedge i_Clock) begin
    exp_t e;
    int   lat;
    if (!i_Reset) begin
      if (o_Rx_DV && o_Rx_Frame_Err) begin
        checkOutput("dv_and_ferr_together", 32'd1, 32'd0);
      end else if (o_Rx_DV || o_Rx_Frame_Err) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", 32'({o_Rx_Frame_Err, o_Rx_DV}), 32'd0);
        end else begin
          e   = exp_q.pop_front();
          lat = cycle - e.start_cycle;
          checkOutput("pulse_is_frame_err", 32'(o_Rx_Frame_Err), 32'(e.is_err));
          checkOutput("rx_byte", 32'(o_Rx_Byte), 32'(e.data));
          checkOutput("latency_152_to_156", 32'(lat >= 152 && lat <= 156), 32'd1);
        end
      end
    end
  end

  initial begin
    i_Reset     = 1'b1;
    i_Rx_Serial = 1'b1;
    #2;
    checkResetOutputs("reset");
    repeat (3) @(negedge i_Clock);
    i_Reset = 1'b0;
    repeat (5) @(negedge i_Clock);
    checkResetOutputs("after_reset");

    applyStimulus(8'hA5, 1'b1, -1);
    repeat (20) @(negedge i_Clock);

    applyStimulus(8'h00, 1'b1, -1);
    applyStimulus(8'hFF, 1'b1, -1);
    repeat (20) @(negedge i_Clock);

    // Five-cycle glitch: start is accepted, then rejected at mid-bit
    i_Rx_Serial = 1'b0;
    repeat (5) @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
    checkOutput("glitch_busy_seen", 32'(o_Rx_Busy), 32'd1);
    repeat (8) @(negedge i_Clock);
    checkOutput("glitch_busy_dropped", 32'(o_Rx_Busy), 32'd0);
    repeat (20) @(negedge i_Clock);

    applyStimulus(8'h3C, 1'b0, -1);
    repeat (20) @(negedge i_Clock);

    // 400-cycle break: one all-zero frame, then busy holds until the line rises
    begin
      exp_t e;
      e.start_cycle = cycle;
      if (FRAMING) begin
        e.is_err = 1'b1;
        e.data   = last_byte;
      end else begin
        e.is_err  = 1'b0;
        e.data    = 8'h00;
        last_byte = 8'h00;
      end
      exp_q.push_back(e);
    end
    i_Rx_Serial = 1'b0;
    repeat (390) @(negedge i_Clock);
    checkOutput("break_busy_held", 32'(o_Rx_Busy), 32'd1);
    repeat (10) @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
    repeat (5) @(negedge i_Clock);
    checkOutput("break_busy_released", 32'(o_Rx_Busy), 32'd0);
    repeat (20) @(negedge i_Clock);

    applyStimulus(8'h5A, 1'b1, -1);
    repeat (20) @(negedge i_Clock);

    applyStimulus(8'hC3, 1'b1, 4);
    applyStimulus(8'h81, 1'b1, -1);

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge i_Clock);
    checkOutput("pending_expectations", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge i_Clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
